// File: rtl/idct_8x8_serial_if.sv
// Coefficient-in / pixel-out stream bundle for the serial 8x8 IDCT.
interface idct_8x8_serial_if #(
    parameter int COEF_W = 12
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_data;
    logic                     out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/idct_8x8_serial.sv
// Serial 8x8 inverse DCT: load 64 coefficients, run two matrix passes through a
// transpose buffer, then stream 64 level-shifted, clamped pixels.
module idct_8x8_serial #(
    parameter int COEF_W = 12,
    parameter int TMP_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    idct_8x8_serial_if.slave io,
    output logic             busy
);
    localparam int ACC1_W = COEF_W + 12;
    localparam int ACC2_W = TMP_W + 12;

    typedef enum logic [1:0] {LOAD = 2'd0, PASS1 = 2'd1, PASS2 = 2'd2} state_t;

    localparam logic signed [7:0] RM [8][8] = '{
        '{8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
        '{8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
        '{8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
        '{8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
        '{8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
        '{8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
        '{8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
        '{8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
    };

    function automatic logic signed [TMP_W-1:0] sat_tmp(input logic signed [ACC1_W-1:0] v);
        if (!v[ACC1_W-1] && (|v[ACC1_W-2:TMP_W-1])) begin
            return {1'b0, {(TMP_W-1){1'b1}}};
        end else if (v[ACC1_W-1] && !(&v[ACC1_W-2:TMP_W-1])) begin
            return {1'b1, {(TMP_W-1){1'b0}}};
        end else begin
            return v[TMP_W-1:0];
        end
    endfunction

    function automatic logic [7:0] clamp_pix(input logic signed [ACC2_W-1:0] v);
        logic signed [ACC2_W-1:0] p;
        p = v + ACC2_W'(9'sd128);
        if (p[ACC2_W-1]) begin
            return 8'd0;
        end else if (|p[ACC2_W-2:8]) begin
            return 8'd255;
        end else begin
            return p[7:0];
        end
    endfunction

    state_t                    state_r, state_s;
    logic [5:0]                cnt_r, cnt_s;
    logic                      in_ready_r, busy_r, out_valid_r, out_valid_s, out_last_r;
    logic [7:0]                out_data_r, pix_s;
    logic                      coef_we_s, t_we_s, pix_ld_s, done_s;
    logic signed [COEF_W-1:0]  coef_r [64];
    logic signed [TMP_W-1:0]   t_r [64];
    logic signed [TMP_W-1:0]   t_val_s;
    logic signed [ACC1_W-1:0]  acc1_s;
    logic signed [ACC2_W-1:0]  acc2_s;

    // Sequencer next-state and strobes; cnt_r walks raster order in every state.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r;
        coef_we_s   = 1'b0;
        t_we_s      = 1'b0;
        pix_ld_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            LOAD: begin
                if (io.in_valid && in_ready_r) begin
                    coef_we_s = 1'b1;
                    cnt_s     = cnt_r + 6'd1;
                    state_s   = (cnt_r == 6'd63) ? PASS1 : LOAD;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            PASS1: begin
                t_we_s  = 1'b1;
                cnt_s   = cnt_r + 6'd1;
                state_s = (cnt_r == 6'd63) ? PASS2 : PASS1;
            end
            PASS2: begin
                if (out_valid_r && io.out_ready && out_last_r) begin
                    done_s      = 1'b1;
                    out_valid_s = 1'b0;
                    state_s     = LOAD;
                end else if (!out_valid_r || io.out_ready) begin
                    pix_ld_s    = 1'b1;
                    out_valid_s = 1'b1;
                    cnt_s       = cnt_r + 6'd1;
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            default: begin
                state_s     = LOAD;
                cnt_s       = 6'd0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Eight-tap dot products for the element at cnt_r: Y column for pass 1, T row for pass 2.
    always_comb begin
        acc1_s = {ACC1_W{1'b0}};
        acc2_s = {ACC2_W{1'b0}};
        for (int k = 0; k < 8; k++) begin
            acc1_s = acc1_s + ACC1_W'(coef_r[{3'(k), cnt_r[2:0]}]) * ACC1_W'(RM[k][cnt_r[5:3]]);
            acc2_s = acc2_s + ACC2_W'(t_r[{cnt_r[5:3], 3'(k)}]) * ACC2_W'(RM[k][cnt_r[2:0]]);
        end
        t_val_s = sat_tmp((acc1_s + ACC1_W'(8'sd64)) >>> 3'd7);
        pix_s   = clamp_pix((acc2_s + ACC2_W'(8'sd64)) >>> 3'd7);
    end

    // State and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= LOAD;
            cnt_r       <= 6'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= (state_s == LOAD);
            busy_r      <= (state_s != LOAD);
            out_valid_r <= out_valid_s;
        end
    end

    // Output pixel register; holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r <= 8'd0;
            out_last_r <= 1'b0;
        end else if (pix_ld_s) begin
            out_data_r <= pix_s;
            out_last_r <= (cnt_r == 6'd63);
        end else if (done_s) begin
            out_last_r <= 1'b0;
        end
    end

    // Coefficient and transpose buffers; contents need no reset.
    always_ff @(posedge clk) begin
        if (coef_we_s) begin
            coef_r[cnt_r] <= io.in_data;
        end
        if (t_we_s) begin
            t_r[cnt_r] <= t_val_s;
        end
    end

    assign io.in_ready  = in_ready_r;
    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;
    assign io.out_last  = out_last_r;
    assign busy         = busy_r;
endmodule

// File: tb/tb_idct_8x8_serial.sv
// Directed bench for idct_8x8_serial with an expected-pixel queue fed from a
// bench-side integer model or known constant results.
module tb_idct_8x8_serial;
    logic clk = 1'b0;
    logic rst;
    logic busy;

    idct_8x8_serial_if #(.COEF_W(12)) bus ();
    idct_8x8_serial #(.COEF_W(12), .TMP_W(16)) dut (.clk(clk), .rst(rst), .io(bus), .busy(busy));

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    int         pix_idx = 0;
    int         done_blocks = 0;
    bit         rand_rdy = 1'b0;
    bit         stall_pend = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    int rm [8][8] = '{
        '{45,  45,  45,  45,  45,  45,  45,  45},
        '{63,  53,  36,  12, -12, -36, -53, -63},
        '{59,  24, -24, -59, -59, -24,  24,  59},
        '{53, -12, -63, -36,  36,  63,  12, -53},
        '{45, -45, -45,  45,  45, -45, -45,  45},
        '{36, -63,  12,  53, -53, -12,  63, -36},
        '{24, -59,  59, -24, -24,  59, -59,  24},
        '{12, -36,  53, -63,  63, -53,  36, -12}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: X = R' * Y * R in plain integers, floor shifts, saturation and clamp.
    function automatic void model_push(input int y[64]);
        int t[64];
        int s;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += rm[k][i] * y[k*8+j];
                s = (s + 64) >>> 7;
                if (s > 32767) s = 32767;
                else if (s < -32768) s = -32768;
                t[i*8+j] = s;
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s += t[i*8+k] * rm[k][j];
                s = ((s + 64) >>> 7) + 128;
                if (s > 255) s = 255;
                else if (s < 0) s = 0;
                exp_q.push_back(8'(s));
            end
        end
    endfunction

    task automatic send_block(input int y[64], input int dc_pix, input bit keep, input int min_done);
        int n = 0;
        int guard = 0;
        if (dc_pix < 0) model_push(y);
        else for (int p = 0; p < 64; p++) exp_q.push_back(8'(dc_pix));
        while (n < 64 && guard < 3000) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(y[n]);
            if (bus.in_ready) begin
                if (n == 0 && min_done > 0) check("block_order", 32'(done_blocks >= min_done), 32'd1);
                n++;
            end
            guard++;
        end
        check("send_timeout", n, 64);
        if (!keep) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int guard = 0;
        while (done_blocks < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("done_timeout", done_blocks, target);
    endtask

    // Output side: drive out_ready, pop the scoreboard on each beat, check stall stability.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = rand_rdy ? ($urandom_range(1) == 1) : 1'b1;
            if (stall_pend) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, held_data);
                check("hold_last", bus.out_last, held_last);
            end
            stall_pend = 1'b0;
            if (bus.out_valid && !rst) begin
                if (bus.out_ready) begin
                    check("pixel_avail", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("pixel", bus.out_data, exp_q.pop_front());
                    check("out_last", bus.out_last, 32'(pix_idx == 63));
                    if (pix_idx == 63) begin
                        pix_idx = 0;
                        done_blocks++;
                    end else begin
                        pix_idx++;
                    end
                end else begin
                    stall_pend = 1'b1;
                    held_data  = bus.out_data;
                    held_last  = bus.out_last;
                end
            end
        end
    end

    initial begin
        int blk[64];
        int blk_b[64];
        int c;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 12'sd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1);

        // All-zero block with in_valid held high: latency and mid-grey output.
        blk = '{default: 0};
        send_block(blk, 128, 1'b1, 0);
        c = 0;
        while (!bus.out_valid && c < 200) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check("in_ready_pass1", bus.in_ready, 0);
                check("busy_pass1", busy, 1);
            end
        end
        check("first_out_latency", c, 66);
        bus.in_valid = 1'b0;
        wait_done(1);
        @(negedge clk);
        check("in_ready_return", bus.in_ready, 1);
        check("busy_idle", busy, 0);

        // DC-only blocks, including both saturating extremes.
        blk = '{default: 0};
        blk[0] = 64;
        send_block(blk, 136, 1'b0, 0);
        wait_done(2);
        blk[0] = 2047;
        send_block(blk, 255, 1'b0, 0);
        wait_done(3);
        blk[0] = -2048;
        send_block(blk, 0, 1'b0, 0);
        wait_done(4);

        // Same random block without and with output backpressure.
        for (int p = 0; p < 64; p++) blk[p] = int'($urandom_range(600)) - 300;
        send_block(blk, -1, 1'b0, 0);
        wait_done(5);
        rand_rdy = 1'b1;
        send_block(blk, -1, 1'b0, 0);
        wait_done(6);
        rand_rdy = 1'b0;

        // Reset in the middle of the pixel stream.
        blk = '{default: 0};
        blk[0] = 64;
        send_block(blk, 136, 1'b0, 0);
        c = 0;
        while (pix_idx < 20 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("reach_20_pixels", 32'(pix_idx >= 20), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        pix_idx = 0;
        stall_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        repeat (3) @(negedge clk);
        check("no_stale_pixel", bus.out_valid, 0);
        send_block(blk, 136, 1'b0, 0);
        wait_done(7);

        // Two random blocks back to back with in_valid held high.
        for (int p = 0; p < 64; p++) begin
            blk[p]   = int'($urandom_range(400)) - 200;
            blk_b[p] = int'($urandom_range(2000)) - 1000;
        end
        send_block(blk, -1, 1'b1, 0);
        send_block(blk_b, -1, 1'b1, 8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(9);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
